seq_pattern_tx: RTL and testbench

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

---
 rtl/seq_pattern_tx.sv | 126 ++++++++++++
 tb/tb_seq_pattern_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter that shifts a loaded pattern out MSB-first and
// produces the expected Mealy '101' detector response alongside each bit.
module seq_pattern_tx #(
   parameter int WIDTH = 8,
   parameter int LW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic [LW-1:0]    load_len,
   output logic             x,
   output logic             x_valid,
   output logic             z_exp,
   output logic             busy,
   output logic             done,
   output logic [LW-1:0]    det_count
);

   typedef enum logic {IDLE, SHIFT} state_t;
   typedef enum logic [1:0] {T0, T1, T10} trk_t;

   localparam logic [LW-1:0] WIDTH_L = LW'(WIDTH);

   state_t           r_state;
   state_t           w_stateNext;
   trk_t             r_trk;
   trk_t             w_trkNext;
   logic [WIDTH-1:0] r_shift;
   logic [LW-1:0]    r_cnt;
   logic [LW-1:0]    r_detCount;
   logic             r_ready;
   logic             r_done;
   logic             w_handshake;
   logic             w_lastBit;
   logic             w_xValid;
   logic             w_x;
   logic             w_z;
   logic [LW-1:0]    w_len;

   assign w_handshake = load_valid & r_ready;
   assign w_len       = (load_len > WIDTH_L) ? WIDTH_L : load_len;
   assign w_xValid    = (r_state == SHIFT);
   assign w_x         = w_xValid & r_shift[WIDTH-1];
   assign w_lastBit   = w_xValid && (r_cnt == LW'(1));
   assign w_z         = w_xValid & w_x & (r_trk == T10);

   assign x          = w_x;
   assign x_valid    = w_xValid;
   assign z_exp      = w_z;
   assign busy       = w_xValid;
   assign done       = r_done;
   assign load_ready = r_ready;
   assign det_count  = r_detCount;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_trk   <= T0;
      end else begin
         r_state <= w_stateNext;
         r_trk   <= w_trkNext;
      end
   end

   // The tracker restarts on every accepted frame so no prefix leaks across frames.
   always_comb begin
      w_stateNext = r_state;
      w_trkNext   = r_trk;
      case (r_state)
         IDLE: begin
            if (w_handshake && (w_len != '0)) w_stateNext = SHIFT;
         end
         SHIFT: begin
            if (w_lastBit) w_stateNext = IDLE;
         end
         default: w_stateNext = IDLE;
      endcase
      if (w_handshake) begin
         w_trkNext = T0;
      end else if (w_xValid) begin
         case (r_trk)
            T0:      w_trkNext = w_x ? T1 : T0;
            T1:      w_trkNext = w_x ? T1 : T10;
            T10:     w_trkNext = w_x ? T1 : T0;
            default: w_trkNext = T0;
         endcase
      end
   end

   // Patterns are left-aligned on capture so the MSB of the shift register is always the next bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift    <= '0;
         r_cnt      <= '0;
         r_detCount <= '0;
         r_ready    <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_handshake) begin
            r_detCount <= '0;
            r_shift    <= load_data << (WIDTH_L - w_len);
            r_cnt      <= w_len;
            if (w_len == '0) begin
               r_done  <= 1'b1;
               r_ready <= 1'b1;
            end else begin
               r_ready <= 1'b0;
            end
         end else if (w_xValid) begin
            r_shift <= r_shift << 1;
            r_cnt   <= r_cnt - LW'(1);
            if (w_z) r_detCount <= r_detCount + LW'(1);
            if (w_lastBit) begin
               r_done  <= 1'b1;
               r_ready <= 1'b1;
            end
         end else begin
            r_ready <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed and random-pattern bench for seq_pattern_tx, with an independent
// history-based '101' detector driven by the serial loopback.
module tb_seq_pattern_tx;

   logic       clk;
   logic       rst;
   logic       load_valid;
   logic       load_ready;
   logic [7:0] load_data;
   logic [3:0] load_len;
   logic       x;
   logic       x_valid;
   logic       z_exp;
   logic       busy;
   logic       done;
   logic [3:0] det_count;

   int vectors     = 0;
   int miscompares = 0;

   seq_pattern_tx #(.WIDTH(8), .LW(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_len   (load_len),
      .x          (x),
      .x_valid    (x_valid),
      .z_exp      (z_exp),
      .busy       (busy),
      .done       (done),
      .det_count  (det_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference detector: a '101' ends here when the two previous valid bits of this frame were '10'.
   logic [1:0] mHist;
   int         mCnt;
   logic       mZ;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mHist <= 2'b00;
         mCnt  <= 0;
      end else if (load_valid && load_ready) begin
         mHist <= 2'b00;
         mCnt  <= 0;
      end else if (x_valid) begin
         mHist <= {mHist[0], x};
         mCnt  <= (mCnt < 2) ? mCnt + 1 : 2;
      end
   end
   assign mZ = x_valid && x && (mCnt >= 2) && (mHist == 2'b10);

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Called at a falling edge; returns at the falling edge of the done cycle.
   task automatic applyStimulus(input logic [7:0] data, input logic [3:0] len,
                                input logic [7:0] zMask, input logic [3:0] expCount,
                                input bit holdValid);
      int effLen;
      effLen     = (len > 4'd8) ? 8 : int'(len);
      load_valid = 1'b1;
      load_data  = data;
      load_len   = len;
      @(negedge clk);
      load_valid = holdValid;
      for (int i = 0; i < effLen; i++) begin
         if (holdValid) begin
            load_data = ~data;
            load_len  = 4'd3;
         end
         checkOutput("bit_valid", 32'(x_valid), 32'd1);
         checkOutput("bit_busy",  32'(busy),    32'd1);
         checkOutput("bit_ready", 32'(load_ready), 32'd0);
         checkOutput("bit_x",     32'(x),       32'(data[effLen-1-i]));
         checkOutput("bit_z",     32'(z_exp),   32'(zMask[i]));
         @(negedge clk);
      end
      checkOutput("end_done",  32'(done),       32'd1);
      checkOutput("end_valid", 32'(x_valid),    32'd0);
      checkOutput("end_ready", 32'(load_ready), 32'd1);
      checkOutput("end_count", 32'(det_count),  32'(expCount));
      if (!holdValid) load_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0] data;
      logic [3:0] len;
      int         bitIdx;
      bit         sawDone;

      rst        = 1'b1;
      load_valid = 1'b0;
      load_data  = 8'h00;
      load_len   = 4'd0;
      @(negedge clk);
      checkOutput("rst_ready", 32'(load_ready), 32'd0);
      checkOutput("rst_valid", 32'(x_valid),    32'd0);
      checkOutput("rst_done",  32'(done),       32'd0);
      checkOutput("rst_count", 32'(det_count),  32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_ready", 32'(load_ready), 32'd1);

      $display("[TB] 8-bit frame 10101101");
      applyStimulus(8'b10101101, 4'd8, 8'b10010100, 4'd3, 1'b0);
      @(negedge clk);
      checkOutput("done_pulse_once", 32'(done), 32'd0);

      $display("[TB] 5-bit overlap frame 10101");
      applyStimulus(8'b00010101, 4'd5, 8'b00010100, 4'd2, 1'b0);

      $display("[TB] zero-length frame");
      applyStimulus(8'hFF, 4'd0, 8'h00, 4'd0, 1'b0);
      @(negedge clk);
      checkOutput("len0_done_clear", 32'(done),       32'd0);
      checkOutput("len0_ready",      32'(load_ready), 32'd1);

      $display("[TB] clamped length 15 -> 8");
      applyStimulus(8'b10101101, 4'd15, 8'b10010100, 4'd3, 1'b0);
      @(negedge clk);

      $display("[TB] back-to-back frames");
      applyStimulus(8'b00001011, 4'd4, 8'b00000100, 4'd1, 1'b1);
      applyStimulus(8'b00001011, 4'd4, 8'b00000100, 4'd1, 1'b1);
      applyStimulus(8'b00000110, 4'd3, 8'b00000000, 4'd0, 1'b1);
      applyStimulus(8'b00001011, 4'd4, 8'b00000100, 4'd1, 1'b0);
      @(negedge clk);

      $display("[TB] reset on third bit");
      load_valid = 1'b1;
      load_data  = 8'b10101101;
      load_len   = 4'd8;
      @(negedge clk);
      load_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("abort_running", 32'(x_valid), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("abort_valid", 32'(x_valid),    32'd0);
      checkOutput("abort_x",     32'(x),          32'd0);
      checkOutput("abort_busy",  32'(busy),       32'd0);
      checkOutput("abort_z",     32'(z_exp),      32'd0);
      checkOutput("abort_ready", 32'(load_ready), 32'd0);
      checkOutput("abort_count", 32'(det_count),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checkOutput("abort_no_done", 32'(done), 32'd0);
         checkOutput("abort_idle",    32'(busy), 32'd0);
         checkOutput("abort_ready_after", 32'(load_ready), 32'd1);
      end
      applyStimulus(8'b10101101, 4'd8, 8'b10010100, 4'd3, 1'b0);
      @(negedge clk);

      $display("[TB] random loopback patterns");
      for (int p = 0; p < 32; p++) begin
         data       = 8'($urandom);
         len        = 4'($urandom_range(1, 8));
         load_valid = 1'b1;
         load_data  = data;
         load_len   = len;
         @(negedge clk);
         load_valid = 1'b0;
         bitIdx     = 0;
         sawDone    = 1'b0;
         for (int c = 0; c < 11; c++) begin
            if (done) begin
               sawDone = 1'b1;
               break;
            end
            if (x_valid) begin
               checkOutput("rnd_x", 32'(x),     32'(data[int'(len)-1-bitIdx]));
               checkOutput("rnd_z", 32'(z_exp), 32'(mZ));
               bitIdx++;
            end
            @(negedge clk);
         end
         checkOutput("rnd_done", 32'(sawDone), 32'd1);
         checkOutput("rnd_bits", 32'(bitIdx),  32'(len));
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
